// File: rtl/pwm_generator.sv
// pwm_generator: period-counting PWM output stage with double-buffered
// period (top) and duty (compare) settings. New settings take effect only
// at a period boundary, so a running period is never cut short or stretched.
module pwm_generator (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_top,
    input  logic       i_top_valid,
    input  logic [8:0] i_compare,
    input  logic       i_compare_valid,
    output logic       o_pwm,
    output logic [7:0] o_count,
    output logic       o_period_start,
    output logic       o_pending
);

    // Active settings, shadow settings and their pending flags.
    logic [7:0] top_a;
    logic [8:0] cmp_a;
    logic [7:0] top_s;
    logic [8:0] cmp_s;
    logic       top_p;
    logic       cmp_p;
    logic [7:0] count;
    logic       pwm_q;
    logic       period_start_q;

    // Next-state values.
    logic       boundary;
    logic [7:0] count_n;
    logic [7:0] top_a_n;
    logic [8:0] cmp_a_n;
    logic [7:0] top_s_n;
    logic [8:0] cmp_s_n;
    logic       top_p_n;
    logic       cmp_p_n;
    logic       pwm_n;

    // Handshake: i_top_valid / i_compare_valid are single-cycle strobes with
    // no back-pressure; every strobe is captured on the edge it is sampled.
    // A strobe that coincides with the boundary edge bypasses the shadow and
    // goes straight into the active register.

    // Compute boundary, counter, settings and output for the next edge.
    always_comb begin
        boundary = (count == top_a);
        count_n  = boundary ? 8'd0 : count + 8'd1;

        top_s_n  = i_top_valid     ? i_top     : top_s;
        cmp_s_n  = i_compare_valid ? i_compare : cmp_s;

        top_a_n  = top_a;
        cmp_a_n  = cmp_a;
        top_p_n  = top_p | i_top_valid;
        cmp_p_n  = cmp_p | i_compare_valid;

        if (boundary) begin
            if (i_top_valid) begin
                top_a_n = i_top;
            end else if (top_p) begin
                top_a_n = top_s;
            end
            if (i_compare_valid) begin
                cmp_a_n = i_compare;
            end else if (cmp_p) begin
                cmp_a_n = cmp_s;
            end
            // Everything captured so far has now been applied.
            top_p_n = 1'b0;
            cmp_p_n = 1'b0;
        end

        // Output is derived from next-state values so it lines up with o_count.
        pwm_n = ({1'b0, count_n} < cmp_a_n);
    end

    // State registers; reset aborts the period and drops pending settings.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count          <= 8'd0;
            top_a          <= 8'hFF;
            cmp_a          <= 9'd0;
            top_s          <= 8'd0;
            cmp_s          <= 9'd0;
            top_p          <= 1'b0;
            cmp_p          <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            count          <= count_n;
            top_a          <= top_a_n;
            cmp_a          <= cmp_a_n;
            top_s          <= top_s_n;
            cmp_s          <= cmp_s_n;
            top_p          <= top_p_n;
            cmp_p          <= cmp_p_n;
            pwm_q          <= pwm_n;
            period_start_q <= boundary;
        end
    end

    assign o_pwm          = pwm_q;
    assign o_count        = count;
    assign o_period_start = period_start_q;
    assign o_pending      = top_p | cmp_p;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed bench for pwm_generator with hand-derived
// expectations for period length, duty, strobes and reset behaviour.
module tb_pwm_generator;

    logic       clk;
    logic       rst_n;
    logic [7:0] top;
    logic       top_valid;
    logic [8:0] compare;
    logic       compare_valid;
    logic       pwm;
    logic [7:0] count;
    logic       period_start;
    logic       pending;

    int n_cmp;
    int n_err;

    pwm_generator dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_top           (top),
        .i_top_valid     (top_valid),
        .i_compare       (compare),
        .i_compare_valid (compare_valid),
        .o_pwm           (pwm),
        .o_count         (count),
        .o_period_start  (period_start),
        .o_pending       (pending)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 256-cycle default period starting at count 0 right after reset release.
    task automatic check_default_period();
        for (int i = 1; i <= 256; i++) begin
            step();
            check("def_count", count, i % 256);
            check("def_pwm", pwm, 0);
            check("def_ps", period_start, (i == 256) ? 1 : 0);
            check("def_pend", pending, 0);
        end
    endtask

    // Strobe both settings, then run to the start of the period using them.
    task automatic apply(input logic [7:0] t, input logic [8:0] c);
        int n;
        top = t;
        compare = c;
        top_valid = 1'b1;
        compare_valid = 1'b1;
        step();
        top_valid = 1'b0;
        compare_valid = 1'b0;
        n = 0;
        while (!period_start && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) check("apply_timeout", 1, 0);
    endtask

    // From count 0 of a period, check one whole period then land on next count 0.
    task automatic check_period(input int t, input int high);
        for (int j = 0; j <= t; j++) begin
            check("per_count", count, j);
            check("per_pwm", pwm, (j < high) ? 1 : 0);
            check("per_ps", period_start, (j == 0) ? 1 : 0);
            step();
        end
        check("per_wrap", count, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        top = 8'd0;
        compare = 9'd0;
        top_valid = 1'b0;
        compare_valid = 1'b0;

        // Reset defaults.
        #1;
        check("rst_count", count, 0);
        check("rst_pwm", pwm, 0);
        check("rst_ps", period_start, 0);
        check("rst_pend", pending, 0);
        step();
        step();
        rst_n = 1'b1;
        check_default_period();

        // Sequencer stream: strobe on cycle 4 of the first period.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("seq_count4", count, 4);
        top = 8'hFF;
        compare = 9'h080;
        top_valid = 1'b1;
        compare_valid = 1'b1;
        step();
        top_valid = 1'b0;
        compare_valid = 1'b0;
        for (int i = 5; i < 256; i++) begin
            check("seq_pend", pending, 1);
            check("seq_pwm_old", pwm, 0);
            step();
        end
        check("seq_pend_clr", pending, 0);
        check_period(255, 128);
        check_period(255, 128);

        // Extremes.
        apply(8'd9, 9'd0);
        check_period(9, 0);
        check_period(9, 0);
        apply(8'd9, 9'd10);
        check_period(9, 10);
        apply(8'hFF, 9'h100);
        check_period(255, 256);

        // Mid-period change, last strobe wins.
        apply(8'd9, 9'd5);
        for (int j = 0; j <= 9; j++) begin
            check("mid_count", count, j);
            check("mid_pwm", pwm, (j < 5) ? 1 : 0);
            check("mid_pend", pending, (j >= 3) ? 1 : 0);
            compare_valid = 1'b0;
            if (j == 2) begin compare = 9'd2; compare_valid = 1'b1; end
            if (j == 4) begin compare = 9'd7; compare_valid = 1'b1; end
            step();
        end
        compare_valid = 1'b0;
        check("mid_pend_clr", pending, 0);
        check_period(9, 7);

        // Boundary collision: top=3 strobed on the count==top edge.
        for (int j = 0; j < 9; j++) step();
        check("col_count9", count, 9);
        top = 8'd3;
        top_valid = 1'b1;
        step();
        top_valid = 1'b0;
        check("col_pend", pending, 0);
        check_period(3, 7);
        check("col_pend2", pending, 0);

        // top=0: every edge is a boundary.
        for (int j = 0; j < 3; j++) step();
        check("z_count3", count, 3);
        top = 8'd0;
        top_valid = 1'b1;
        step();
        top_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("z_ps", period_start, 1);
            check("z_count", count, 0);
            check("z_pwm", pwm, 1);
            check("z_pend", pending, 0);
            step();
        end

        // Reset mid-operation with a pending update.
        apply(8'd9, 9'd5);
        check_period(9, 5);
        for (int j = 0; j < 3; j++) step();
        compare = 9'd1;
        compare_valid = 1'b1;
        step();
        compare_valid = 1'b0;
        check("mr_pend", pending, 1);
        check("mr_pwm", pwm, 1);
        check("mr_count", count, 4);
        rst_n = 1'b0;
        #1;
        check("mr_async_count", count, 0);
        check("mr_async_pwm", pwm, 0);
        check("mr_async_pend", pending, 0);
        check("mr_async_ps", period_start, 0);
        step();
        step();
        rst_n = 1'b1;
        check_default_period();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Period-counting PWM output stage that consumes the `top`/`compare` update stream emitted by the PWM sequencer. Holds double-buffered period (`top`) and duty (`compare`) settings, counts each period from 0 to `top`, and drives a glitch-free registered PWM output. New settings are only applied at a period boundary, so a period is never truncated or stretched mid-cycle. Sits between the sequencer and the LED/output pin.

## Interface

Parameters: none. Widths are fixed: `top` is 8 bits, `compare` is 9 bits so that 100% duty is expressible.

Ports:
- `i_clk` input 1: system clock; all state changes on its rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_top` input 8: period setting; period = `i_top`+1 cycles.
- `i_top_valid` input 1: single-cycle strobe; captures `i_top`.
- `i_compare` input 9: duty setting; output is high while count < compare.
- `i_compare_valid` input 1: single-cycle strobe; captures `i_compare`.
- `o_pwm` output 1: registered PWM output.
- `o_count` output 8: current period counter.
- `o_period_start` output 1: one-cycle strobe in the cycle after a wrap.
- `o_pending` output 1: high while any captured setting is not yet applied.

## Operation

- State:
  - Active `top_a[7:0]` and `cmp_a[8:0]`.
  - Shadow `top_s` and `cmp_s`, with per-field pending flags `top_p` and `cmp_p`.
  - Counter `count[7:0]`.
- Capture:
  - `i_top_valid` loads `top_s` and sets `top_p`.
  - `i_compare_valid` loads `cmp_s` and sets `cmp_p`.
  - The two fields are independent. A strobe on one field does not touch the other field.
  - Several strobes within one period: the last one wins.
- Boundary = edge where `count == top_a`. On that edge:
  - `count` goes to 0.
  - For each field: if valid is asserted on this edge, the input value goes straight to active. Otherwise, if that field's pending flag is set, the shadow value goes to active. Pending flags for applied fields clear.
  - A valid arriving on the boundary edge therefore takes effect in the period that starts on that edge, and leaves its pending flag clear.
- Non-boundary edge: `count` increments by 1.
- Output: `o_pwm` is registered from the next-state values, so in any cycle `o_pwm == (o_count < cmp_a)` using a 9-bit compare with `o_count` zero-extended.
  - `cmp_a == 0`: output is always low.
  - `cmp_a > top_a`: output is always high (100% duty).
- `top_a == 0`:
  - Every edge is a boundary and the period is 1 cycle.
  - `o_period_start` stays high continuously while `top_a == 0`.
- `o_pending = top_p | cmp_p`.
- Reset (asynchronous, while `i_rst_n` is low):
  - `count` = 0, `top_a` = 0xFF, `cmp_a` = 0.
  - Shadow registers are cleared to 0 and both pending flags are cleared.
  - `o_pwm` = 0, `o_period_start` = 0, `o_pending` = 0.
  - Reset asserted mid-period aborts the period immediately and discards any pending settings.

## Timing

- The first period after reset release starts with `count` = 0 and runs 256 cycles at 0% duty.
  - `o_period_start` is not asserted for this first period.
- Update latency: a setting captured in period N is applied from the first cycle of period N+1. Exception: a setting captured on the boundary edge itself (see Operation).
- `o_period_start` is high for exactly the one cycle in which `o_count == 0` following a wrap.
- Period length = `top_a`+1 cycles, where `top_a` is the value latched at the start of that period.
- High time per period = min(`cmp_a`, `top_a`+1) cycles, contiguous, starting at `count` 0.
- No combinational path from any input to any output.

## Test plan

- **Reset defaults**: hold `i_rst_n` low, then release with no strobes. Expect 256-cycle periods, `o_pwm` constantly 0, first `o_period_start` on cycle 256, `o_pending` = 0.
- **Sequencer stream**: `top` = 0xFF and `compare` = 0x80 strobed together on cycle 4. Expect `o_pending` = 1 until the boundary at cycle 255. From the next period, `o_pwm` is high for 128 cycles then low for 128 cycles, repeating.
- **Extremes**:
  - `top` = 9, `compare` = 0: 10-cycle period, output always low.
  - `compare` = 10 with `top` = 9: output always high.
  - `compare` = 0x100 with `top` = 0xFF: output always high.
- **Mid-period change and last-wins**: with `top` = 9 and `compare` = 5 running, strobe `compare` = 2 and then `compare` = 7 mid-period. The current period keeps 5 high cycles; the next period has 7 high cycles.
- **Boundary collision**: strobe `top` = 3 on the exact edge where `count == top_a`. Expect the new period to be 4 cycles immediately and `o_pending` to stay 0. Also cover `top` = 0: `o_period_start` stays high continuously.
- **Reset mid-operation**: assert `i_rst_n` low mid-period while an update is pending. Outputs clear asynchronously (before the next clock edge). After release, behaviour matches reset defaults and the pending update is discarded.
